aximm2s_rdstream: RTL and testbench

- Read-data stage directly downstream of the aximm2s control/AR-issue logic.
- Consumes AXI4 R-channel beats for one programmed transfer and buffers them in a synchronous FIFO.
- Emits the data as an AXI-stream with TLAST on the final word of the transfer.
- Reports FIFO fill back for burst throttling, and reports busy, error and completion to the control register block.

---
 rtl/aximm2s_rdstream.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_aximm2s_rdstream.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aximm2s_rdstream.sv
// AXI4 R-channel to AXI-stream read stage: buffers one programmed transfer in a FWFT FIFO and frames it with TLAST.
// Optional byte realignment of the read data is enabled with the AXIMM2S_REALIGN_EN macro.
module aximm2s_rdstream #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int AXI_ID           = 0,
   parameter int LGFIFO           = 9,
   parameter int LGLENW           = 18,
   parameter int C_AXI_ID_WIDTH   = 1
) (
   input  logic                                  S_AXI_ACLK,
   input  logic                                  S_AXI_ARESETN,
   input  logic                                  i_start,
   input  logic [LGLENW-1:0]                     i_len_w,
   input  logic [$clog2(C_AXI_DATA_WIDTH)-4:0]   i_offset,
   input  logic                                  i_abort,
   input  logic                                  i_ar_idle,
   output logic                                  o_busy,
   output logic                                  o_complete,
   output logic                                  o_err,
   output logic [LGFIFO:0]                       o_fifo_fill,
   input  logic                                  M_AXI_RVALID,
   output logic                                  M_AXI_RREADY,
   input  logic [C_AXI_ID_WIDTH-1:0]             M_AXI_RID,
   input  logic [C_AXI_DATA_WIDTH-1:0]           M_AXI_RDATA,
   input  logic [1:0]                            M_AXI_RRESP,
   input  logic                                  M_AXI_RLAST,
   output logic                                  M_AXIS_TVALID,
   input  logic                                  M_AXIS_TREADY,
   output logic [C_AXI_DATA_WIDTH-1:0]           M_AXIS_TDATA,
   output logic                                  M_AXIS_TLAST
);

   localparam int DW    = C_AXI_DATA_WIDTH;
   localparam int OW    = $clog2(C_AXI_DATA_WIDTH) - 3;
   localparam int DEPTH = 1 << LGFIFO;
   localparam logic [C_AXI_ID_WIDTH-1:0] EXP_ID   = C_AXI_ID_WIDTH'(AXI_ID);
   localparam logic [LGFIFO:0]           FULL_LVL = (LGFIFO+1)'(DEPTH);
   localparam logic [LGLENW:0]           CNT_ONE  = (LGLENW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_WAIT_OUT = 2'd2,
      S_DRAIN    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [LGLENW:0]     cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                complete_q, complete_d;
   logic                err_q, err_d;
   logic                rready_q, rready_d;
   logic [LGFIFO:0]     fill_q, fill_d;

   logic [DW:0]         mem [DEPTH];
   logic [LGFIFO-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LGFIFO:0]     mem_cnt_q, mem_cnt_d;
   logic                out_valid_q;
   logic [DW-1:0]       out_data_q;
   logic                out_last_q;

   logic                r_hs_s, t_hs_s, beat_bad_s, start_ok_s;
   logic                flush_s, fifo_wr_s, wr_last_s, skip_s;
   logic [DW-1:0]       wr_data_s;
   logic [LGLENW:0]     load_cnt_s;
   logic                out_free_s, pop_mem_s, bypass_s, push_mem_s;

   assign r_hs_s     = M_AXI_RVALID && rready_q;
   assign t_hs_s     = out_valid_q && M_AXIS_TREADY;
   assign beat_bad_s = M_AXI_RRESP[1] || (M_AXI_RID != EXP_ID);
   assign start_ok_s = i_start && (i_len_w != '0);

`ifdef AXIMM2S_REALIGN_EN
   logic [OW-1:0]       off_q;
   logic [DW-1:0]       prev_q;
   logic                first_q;

   // Splice the upper bytes of the previous beat with the lower bytes of the current one.
   function automatic logic [DW-1:0] realign_word(input logic [DW-1:0] prev,
                                                  input logic [DW-1:0] cur,
                                                  input logic [OW-1:0] off);
      int sh;
      sh = 8 * int'(off);
      return (prev >> sh) | (cur << (DW - sh));
   endfunction

   assign load_cnt_s = {1'b0, i_len_w} + (LGLENW+1)'(i_offset != '0);
   assign skip_s     = first_q;
   assign wr_data_s  = (off_q == '0) ? M_AXI_RDATA : realign_word(prev_q, M_AXI_RDATA, off_q);

   // Realign state: offset latched at start, previous good beat held for splicing.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         off_q   <= '0;
         prev_q  <= '0;
         first_q <= 1'b0;
      end else if (state_q == S_IDLE && start_ok_s) begin
         off_q   <= i_offset;
         first_q <= (i_offset != '0);
      end else if (state_q == S_RUN && r_hs_s && !i_abort && !beat_bad_s) begin
         prev_q  <= M_AXI_RDATA;
         first_q <= 1'b0;
      end else begin
         off_q   <= off_q;
      end
   end
`else
   logic unused_s;
   assign unused_s   = ^{i_offset, 1'b0};
   assign load_cnt_s = {1'b0, i_len_w};
   assign skip_s     = 1'b0;
   assign wr_data_s  = M_AXI_RDATA;
`endif

   logic unused_in_s;
   assign unused_in_s = ^{M_AXI_RLAST, M_AXI_RRESP[0]};

   // Next-state logic for the transfer FSM and its status outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      complete_d = 1'b0;
      flush_s    = 1'b0;
      fifo_wr_s  = 1'b0;
      wr_last_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_ok_s) begin
               state_d = S_RUN;
               cnt_d   = load_cnt_s;
               err_d   = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (i_abort) begin
               flush_s = 1'b1;
               state_d = S_DRAIN;
            end else if (r_hs_s && beat_bad_s) begin
               err_d   = 1'b1;
               flush_s = 1'b1;
               state_d = S_DRAIN;
            end else if (r_hs_s) begin
               if (skip_s) begin
                  cnt_d = cnt_q - CNT_ONE;
               end else begin
                  fifo_wr_s = 1'b1;
                  wr_last_s = (cnt_q == CNT_ONE);
                  if (cnt_q == CNT_ONE) begin
                     state_d = S_WAIT_OUT;
                  end else begin
                     cnt_d = cnt_q - CNT_ONE;
                  end
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_WAIT_OUT: begin
            if (i_abort) begin
               flush_s = 1'b1;
               state_d = S_DRAIN;
            end else if (t_hs_s && out_last_q) begin
               state_d    = S_IDLE;
               complete_d = 1'b1;
            end else begin
               state_d = S_WAIT_OUT;
            end
         end
         S_DRAIN: begin
            if (i_ar_idle && !M_AXI_RVALID) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FIFO bookkeeping: the output register is refilled from memory first, else bypassed from the write.
   always_comb begin
      out_free_s = !out_valid_q || t_hs_s;
      pop_mem_s  = out_free_s && (mem_cnt_q != '0);
      bypass_s   = out_free_s && (mem_cnt_q == '0) && fifo_wr_s;
      push_mem_s = fifo_wr_s && !bypass_s;
      if (flush_s) begin
         fill_d    = '0;
         mem_cnt_d = '0;
      end else begin
         case ({fifo_wr_s, t_hs_s})
            2'b10:   fill_d = fill_q + (LGFIFO+1)'(1);
            2'b01:   fill_d = fill_q - (LGFIFO+1)'(1);
            default: fill_d = fill_q;
         endcase
         case ({push_mem_s, pop_mem_s})
            2'b10:   mem_cnt_d = mem_cnt_q + (LGFIFO+1)'(1);
            2'b01:   mem_cnt_d = mem_cnt_q - (LGFIFO+1)'(1);
            default: mem_cnt_d = mem_cnt_q;
         endcase
      end
      busy_d   = (state_d != S_IDLE);
      rready_d = ((state_d == S_RUN) && (fill_d != FULL_LVL)) || (state_d == S_DRAIN);
   end

   // Transfer FSM state and registered status outputs.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         complete_q <= 1'b0;
         err_q      <= 1'b0;
         rready_q   <= 1'b0;
         fill_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         complete_q <= complete_d;
         err_q      <= err_d;
         rready_q   <= rready_d;
         fill_q     <= fill_d;
      end
   end

   // FIFO pointers and the registered stream output stage.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else if (flush_s) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         mem_cnt_q <= mem_cnt_d;
         if (push_mem_s) begin
            wr_ptr_q <= wr_ptr_q + LGFIFO'(1);
         end else begin
            wr_ptr_q <= wr_ptr_q;
         end
         if (pop_mem_s) begin
            rd_ptr_q    <= rd_ptr_q + LGFIFO'(1);
            out_valid_q <= 1'b1;
            out_data_q  <= mem[rd_ptr_q][DW-1:0];
            out_last_q  <= mem[rd_ptr_q][DW];
         end else if (bypass_s) begin
            out_valid_q <= 1'b1;
            out_data_q  <= wr_data_s;
            out_last_q  <= wr_last_s;
         end else if (out_free_s) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end else begin
            out_valid_q <= out_valid_q;
         end
      end
   end

   // FIFO storage array.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESETN && push_mem_s) begin
         mem[wr_ptr_q] <= {wr_last_s, wr_data_s};
      end
   end

   assign o_busy        = busy_q;
   assign o_complete    = complete_q;
   assign o_err         = err_q;
   assign o_fifo_fill   = fill_q;
   assign M_AXI_RREADY  = rready_q;
   assign M_AXIS_TVALID = out_valid_q;
   assign M_AXIS_TDATA  = out_data_q;
   assign M_AXIS_TLAST  = out_last_q;

endmodule

// File: tb/tb_aximm2s_rdstream.sv
// Directed bench for aximm2s_rdstream (LGFIFO=2): cycle-exact vector table plus multi-cycle sequences.
module tb_aximm2s_rdstream;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_start, i_abort, i_ar_idle;
   logic [17:0] i_len_w;
   logic [1:0]  i_offset;
   logic        o_busy, o_complete, o_err;
   logic [2:0]  o_fifo_fill;
   logic        rvalid, rready, rlast, tvalid, tready, tlast;
   logic [0:0]  rid;
   logic [31:0] rdata, tdata;
   logic [1:0]  rresp;

   always #5 clk = ~clk;

   aximm2s_rdstream #(
      .C_AXI_DATA_WIDTH(32), .AXI_ID(0), .LGFIFO(2), .LGLENW(18), .C_AXI_ID_WIDTH(1)
   ) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
      .i_start(i_start), .i_len_w(i_len_w), .i_offset(i_offset), .i_abort(i_abort),
      .i_ar_idle(i_ar_idle), .o_busy(o_busy), .o_complete(o_complete), .o_err(o_err),
      .o_fifo_fill(o_fifo_fill),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RID(rid), .M_AXI_RDATA(rdata),
      .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
      .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [32:0] cap[$];
   int          n_complete = 0;

   // Stream and completion monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (tvalid && tready) cap.push_back({tlast, tdata});
      if (o_complete) n_complete++;
   end

   logic [31:0] beat_data [8];
   logic [1:0]  beat_resp [8];
   int          beat_idx, n_beats;
   logic        feed_en;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: advance the R-beat feeder past any handshake that happened on this edge.
   task automatic cycle();
      logic hs;
      hs = rvalid && rready;
      @(posedge clk); #1;
      if (hs) beat_idx++;
      rvalid = feed_en && (beat_idx < n_beats);
      rdata  = beat_data[beat_idx % 8];
      rresp  = beat_resp[beat_idx % 8];
   endtask

   task automatic start_xfer(input logic [17:0] len, input logic [1:0] off);
      i_start = 1'b1; i_len_w = len; i_offset = off;
      cycle();
      i_start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 60 && o_busy; k++) cycle();
      check({name, "_idle_timeout"}, 64'(o_busy), 64'd0);
      cycle(); cycle();
   endtask

   typedef struct {
      logic        start;
      logic [17:0] len;
      logic        rv;
      logic [31:0] rd;
      logic        trdy;
      logic        e_rready, e_tvalid;
      logic [31:0] e_tdata;
      logic        e_tlast, e_busy, e_complete;
      logic [2:0]  e_fill;
   } vec_t;

   vec_t vecs [7];
   int   base, cbase;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 18'd4, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 3'd0};
      vecs[1] = '{1'b0, 18'd0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 3'd1};
      vecs[2] = '{1'b0, 18'd0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 3'd1};
      vecs[3] = '{1'b0, 18'd0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 3'd1};
      vecs[4] = '{1'b0, 18'd0, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 3'd1};
      vecs[5] = '{1'b0, 18'd0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 3'd0};
      vecs[6] = '{1'b0, 18'd0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 3'd0};

      rstn = 1'b0; i_start = 1'b0; i_len_w = '0; i_offset = '0; i_abort = 1'b0; i_ar_idle = 1'b1;
      rvalid = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; tready = 1'b0;
      feed_en = 1'b0; beat_idx = 0; n_beats = 0;
      for (int i = 0; i < 8; i++) begin beat_data[i] = '0; beat_resp[i] = 2'b00; end
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_rready", 64'(rready), 64'd0);
      check("rst_tvalid", 64'(tvalid), 64'd0);
      check("rst_fill", 64'(o_fifo_fill), 64'd0);
      check("rst_err", 64'(o_err), 64'd0);
      rstn = 1'b1;
      cycle();

      // Basic transfer, cycle by cycle.
      for (int i = 0; i < 7; i++) begin
         i_start = vecs[i].start; i_len_w = vecs[i].len;
         rvalid = vecs[i].rv; rdata = vecs[i].rd; tready = vecs[i].trdy;
         @(posedge clk); #1;
         check($sformatf("basic%0d_rready", i), 64'(rready), 64'(vecs[i].e_rready));
         check($sformatf("basic%0d_tvalid", i), 64'(tvalid), 64'(vecs[i].e_tvalid));
         if (vecs[i].e_tvalid) check($sformatf("basic%0d_tdata", i), 64'(tdata), 64'(vecs[i].e_tdata));
         check($sformatf("basic%0d_tlast", i), 64'(tlast), 64'(vecs[i].e_tlast));
         check($sformatf("basic%0d_busy", i), 64'(o_busy), 64'(vecs[i].e_busy));
         check($sformatf("basic%0d_complete", i), 64'(o_complete), 64'(vecs[i].e_complete));
         check($sformatf("basic%0d_fill", i), 64'(o_fifo_fill), 64'(vecs[i].e_fill));
         check($sformatf("basic%0d_err", i), 64'(o_err), 64'd0);
      end
      i_start = 1'b0; rvalid = 1'b0;

      // Backpressure: FIFO of 4 fills, then drains in order.
      for (int i = 0; i < 8; i++) begin beat_data[i] = 32'h101 + 32'(i); beat_resp[i] = 2'b00; end
      beat_idx = 0; n_beats = 8; feed_en = 1'b1; tready = 1'b0;
      base = cap.size(); cbase = n_complete;
      start_xfer(18'd8, 2'd0);
      repeat (10) cycle();
      check("bp_accepted", 64'(beat_idx), 64'd4);
      check("bp_rready", 64'(rready), 64'd0);
      check("bp_fill", 64'(o_fifo_fill), 64'd4);
      check("bp_tvalid", 64'(tvalid), 64'd1);
      check("bp_tdata_hold", 64'(tdata), 64'h101);
      tready = 1'b1;
      wait_idle("bp");
      check("bp_count", 64'(cap.size() - base), 64'd8);
      for (int i = 0; i < 8 && base + i < cap.size(); i++)
         check($sformatf("bp_word%0d", i), 64'(cap[base+i]), 64'({(i == 7), 32'h101 + 32'(i)}));
      check("bp_complete", 64'(n_complete - cbase), 64'd1);
      check("bp_fill_end", 64'(o_fifo_fill), 64'd0);

      // Error response on third beat.
      beat_data[0] = 32'h11; beat_data[1] = 32'h22; beat_data[2] = 32'h33; beat_data[3] = 32'h44;
      beat_resp[2] = 2'b10;
      beat_idx = 0; n_beats = 4; feed_en = 1'b1; tready = 1'b1; i_ar_idle = 1'b0;
      base = cap.size(); cbase = n_complete;
      start_xfer(18'd4, 2'd0);
      repeat (8) cycle();
      check("err_flag", 64'(o_err), 64'd1);
      check("err_fill", 64'(o_fifo_fill), 64'd0);
      check("err_tvalid", 64'(tvalid), 64'd0);
      check("err_drain_busy", 64'(o_busy), 64'd1);
      check("err_drain_rready", 64'(rready), 64'd1);
      check("err_all_beats_taken", 64'(beat_idx), 64'd4);
      i_ar_idle = 1'b1;
      repeat (3) cycle();
      check("err_busy_end", 64'(o_busy), 64'd0);
      check("err_no_complete", 64'(n_complete - cbase), 64'd0);
      check("err_words_out", 64'(cap.size() - base), 64'd2);
      for (int i = base; i < cap.size(); i++)
         check("err_no_tlast", 64'(cap[i][32]), 64'd0);
      check("err_sticky", 64'(o_err), 64'd1);
      beat_resp[2] = 2'b00;

      // Abort after two of six beats.
      for (int i = 0; i < 6; i++) beat_data[i] = 32'h61 + 32'(i);
      beat_idx = 0; n_beats = 6; feed_en = 1'b1; tready = 1'b1; i_ar_idle = 1'b0;
      base = cap.size(); cbase = n_complete;
      start_xfer(18'd6, 2'd0);
      check("abort_err_cleared", 64'(o_err), 64'd0);
      for (int k = 0; k < 20 && beat_idx < 2; k++) cycle();
      check("abort_two_beats", 64'(beat_idx), 64'd2);
      i_abort = 1'b1;
      cycle();
      i_abort = 1'b0;
      check("abort_tvalid", 64'(tvalid), 64'd0);
      check("abort_rready", 64'(rready), 64'd1);
      for (int k = 0; k < 20 && beat_idx < 6; k++) cycle();
      check("abort_discarded", 64'(beat_idx), 64'd6);
      check("abort_busy_drain", 64'(o_busy), 64'd1);
      check("abort_tvalid_drain", 64'(tvalid), 64'd0);
      i_ar_idle = 1'b1;
      repeat (3) cycle();
      check("abort_busy_end", 64'(o_busy), 64'd0);
      check("abort_err", 64'(o_err), 64'd0);
      check("abort_no_complete", 64'(n_complete - cbase), 64'd0);
      check("abort_words_out", 64'(cap.size() - base), 64'd2);

      // Reset mid-transfer with three words buffered.
      for (int i = 0; i < 8; i++) beat_data[i] = 32'h201 + 32'(i);
      beat_idx = 0; n_beats = 8; feed_en = 1'b1; tready = 1'b0;
      start_xfer(18'd8, 2'd0);
      for (int k = 0; k < 20 && beat_idx < 3; k++) cycle();
      check("mrst_fill3", 64'(o_fifo_fill), 64'd3);
      feed_en = 1'b0; rvalid = 1'b0; rstn = 1'b0;
      cycle();
      check("mrst_busy", 64'(o_busy), 64'd0);
      check("mrst_complete", 64'(o_complete), 64'd0);
      check("mrst_err", 64'(o_err), 64'd0);
      check("mrst_fill", 64'(o_fifo_fill), 64'd0);
      check("mrst_rready", 64'(rready), 64'd0);
      check("mrst_tvalid", 64'(tvalid), 64'd0);
      check("mrst_tlast", 64'(tlast), 64'd0);
      check("mrst_tdata", 64'(tdata), 64'd0);
      rstn = 1'b1;
      beat_data[0] = 32'hA1; beat_data[1] = 32'hA2;
      beat_idx = 0; n_beats = 2; feed_en = 1'b1; tready = 1'b1;
      base = cap.size(); cbase = n_complete;
      start_xfer(18'd2, 2'd0);
      wait_idle("mrst");
      check("mrst_count", 64'(cap.size() - base), 64'd2);
      if (cap.size() >= base + 2) begin
         check("mrst_word0", 64'(cap[base]), 64'({1'b0, 32'hA1}));
         check("mrst_word1", 64'(cap[base+1]), 64'({1'b1, 32'hA2}));
      end
      check("mrst_complete_once", 64'(n_complete - cbase), 64'd1);

      // Zero-length start is ignored.
      i_start = 1'b1; i_len_w = 18'd0;
      cycle();
      i_start = 1'b0;
      cycle();
      check("zero_len_busy", 64'(o_busy), 64'd0);
      check("zero_len_rready", 64'(rready), 64'd0);

`ifdef AXIMM2S_REALIGN_EN
      beat_data[0] = 32'h44332211; beat_data[1] = 32'h88776655; beat_data[2] = 32'hCCBBAA99;
      beat_idx = 0; n_beats = 3; feed_en = 1'b1; tready = 1'b1;
      base = cap.size(); cbase = n_complete;
      start_xfer(18'd2, 2'd1);
      wait_idle("realign");
      check("realign_beats", 64'(beat_idx), 64'd3);
      check("realign_count", 64'(cap.size() - base), 64'd2);
      if (cap.size() >= base + 2) begin
         check("realign_word0", 64'(cap[base]), 64'({1'b0, 32'h55443322}));
         check("realign_word1", 64'(cap[base+1]), 64'({1'b1, 32'h99887766}));
      end
      check("realign_complete", 64'(n_complete - cbase), 64'd1);
`endif

      feed_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
